per_bus_master: RTL

Host-driven initiator for the BIP peripheral bus. It takes command bytes from a UART receiver byte interface, runs single-word read or write cycles on the peripheral bus (address, chip-select, write/read strobe, data), and returns the result bytes through a UART transmitter byte interface. It is the initiator-side counterpart to the UART peripheral responder, and is used for debug and bootstrap access to bus-mapped resources while the CPU is held in reset.

---
 rtl/per_bus_master.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/per_bus_master.sv
// per_bus_master
//
// Host-driven initiator for the BIP peripheral bus. Command frames arrive as
// bytes from a UART receiver. Each frame runs one single-word read or write
// cycle on the peripheral bus, and the response bytes go back out through a
// UART transmitter byte interface.
//
//   Write frame: 0x57, ADDR_H, ADDR_L, DATA_H, DATA_L  -> response 0x06
//   Read frame : 0x52, ADDR_H, ADDR_L                  -> response DATA_H, DATA_L
//   Any other first byte                              -> response 0x15
//
// Handshake semantics
//   i_rx_valid is a one-cycle pulse that qualifies i_rx_data. A byte is
//   consumed only in IDLE or in a byte-collection state. Pulses in any other
//   state are dropped. o_tx_start is a one-cycle pulse that qualifies
//   o_tx_data. A start is issued only when i_tx_busy is low. i_tx_busy is
//   ignored for the cycle after a start, because the transmitter raises it one
//   cycle late. A byte counts as handed off once i_tx_busy reads low again.
//
// Ports
//   i_clk, i_rst      clock; synchronous active-low reset
//   i_rx_data/valid   received byte stream
//   o_tx_data/start   transmit byte stream; i_tx_busy is transmitter back-pressure
//   o_addr_bus_per    bus address (registered; held until the next access)
//   o_cs_perif        one-cycle chip-select per access
//   o_w_r_per         1 = write, 0 = read; qualified by o_cs_perif
//   o_data_per        write data (registered; held until the next write)
//   o_data_oe         write-data bus enable; high only in the write cycle
//   i_data_per        read data; sampled one cycle after the read chip-select
//   o_cpu_hold        high from the first accepted command byte until IDLE
//   o_dbg_state       current FSM state (0 = IDLE)
//
// Optional feature
//   PER_BUS_MASTER_TIMEOUT_EN: when defined, an inter-byte timer aborts a
//   partially received frame after TIMEOUT_CYCLES clocks without a byte. The
//   block then returns silently to IDLE, with no bus cycle and no response.
module per_bus_master #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_BUS_WIDTH = 10,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [7:0]                i_rx_data,
  input  logic                      i_rx_valid,
  output logic [7:0]                o_tx_data,
  output logic                      o_tx_start,
  input  logic                      i_tx_busy,
  output logic [ADDR_BUS_WIDTH-1:0] o_addr_bus_per,
  output logic                      o_cs_perif,
  output logic                      o_w_r_per,
  output logic [DATA_WIDTH-1:0]     o_data_per,
  output logic                      o_data_oe,
  input  logic [DATA_WIDTH-1:0]     i_data_per,
  output logic                      o_cpu_hold,
  output logic [3:0]                o_dbg_state
);

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_A_H    = 4'd1,
    ST_A_L    = 4'd2,
    ST_D_H    = 4'd3,
    ST_D_L    = 4'd4,
    ST_BUS_WR = 4'd5,
    ST_BUS_RD = 4'd6,
    ST_RD_CAP = 4'd7,
    ST_TX_ACK = 4'd8,
    ST_TX_H   = 4'd9,
    ST_TX_L   = 4'd10,
    ST_NAK    = 4'd11
  } state_t;

  // Sub-phase of a transmit state:
  //   SEND: the byte is still owed.
  //   SKIP: the start was just issued, so i_tx_busy is not yet meaningful.
  //   WAIT: waiting for the transmitter to go idle again.
  typedef enum logic [1:0] {
    PH_SEND = 2'd0,
    PH_SKIP = 2'd1,
    PH_WAIT = 2'd2
  } tx_ph_t;

  state_t state, state_n;
  tx_ph_t tx_ph, ph_n;

  logic                  is_wr;
  logic [7:0]            addr_hi;
  logic [7:0]            addr_lo;
  logic [7:0]            data_hi;
  logic [DATA_WIDTH-1:0] rd_data;

  logic       fire;
  logic [7:0] tx_byte;
  logic [7:0] cur_byte;
  logic       go_wr;
  logic       go_rd;
  logic       to_expired;
  logic [15:0] addr_next;

  // For a read, ADDR_L is the byte arriving right now. For a write, the
  // address was completed two bytes earlier.
  assign addr_next = go_rd ? {addr_hi, i_rx_data} : {addr_hi, addr_lo};

  // Address bits above ADDR_BUS_WIDTH are intentionally discarded.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, addr_next};

  assign o_dbg_state = state;

  // The byte owed by the current transmit state.
  assign cur_byte = (state == ST_NAK)    ? RSP_NAK :
                    (state == ST_TX_ACK) ? RSP_ACK :
                    (state == ST_TX_H)   ? rd_data[15:8] :
                                           rd_data[7:0];

`ifdef PER_BUS_MASTER_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        collecting;

  assign collecting = (state == ST_A_H) || (state == ST_A_L) ||
                      (state == ST_D_H) || (state == ST_D_L);
  // A byte that arrives in the expiry cycle still wins.
  assign to_expired = collecting && !i_rx_valid &&
                      (to_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst || i_rx_valid || !collecting) begin
      to_cnt <= 32'd0;
    end else begin
      to_cnt <= to_cnt + 32'd1;
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign to_expired = 1'b0;
`endif

  // Next-state and strobe decisions
  always_comb begin
    state_n = state;
    ph_n    = tx_ph;
    fire    = 1'b0;
    tx_byte = o_tx_data;
    go_wr   = 1'b0;
    go_rd   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_rx_valid) begin
          state_n = (i_rx_data == CMD_WR || i_rx_data == CMD_RD) ? ST_A_H : ST_NAK;
          ph_n    = PH_SEND;
        end
      end
      ST_A_H: begin
        if (i_rx_valid) state_n = ST_A_L;
      end
      ST_A_L: begin
        if (i_rx_valid) begin
          if (is_wr) begin
            state_n = ST_D_H;
          end else begin
            state_n = ST_BUS_RD;
            go_rd   = 1'b1;
          end
        end
      end
      ST_D_H: begin
        if (i_rx_valid) state_n = ST_D_L;
      end
      ST_D_L: begin
        if (i_rx_valid) begin
          state_n = ST_BUS_WR;
          go_wr   = 1'b1;
        end
      end
      // The first response byte is issued on the way into the transmit state.
      // This lets the start appear on the first cycle of that state.
      ST_BUS_WR: begin
        state_n = ST_TX_ACK;
        ph_n    = PH_SEND;
        if (!i_tx_busy) begin
          fire    = 1'b1;
          tx_byte = RSP_ACK;
          ph_n    = PH_SKIP;
        end
      end
      ST_BUS_RD: begin
        state_n = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        state_n = ST_TX_H;
        ph_n    = PH_SEND;
        if (!i_tx_busy) begin
          fire    = 1'b1;
          tx_byte = i_data_per[15:8];
          ph_n    = PH_SKIP;
        end
      end
      ST_TX_ACK, ST_TX_H, ST_TX_L, ST_NAK: begin
        case (tx_ph)
          PH_SEND: begin
            if (!i_tx_busy) begin
              fire    = 1'b1;
              tx_byte = cur_byte;
              ph_n    = PH_SKIP;
            end
          end
          PH_SKIP: begin
            ph_n = PH_WAIT;
          end
          default: begin
            if (!i_tx_busy) begin
              if (state == ST_TX_H) begin
                state_n = ST_TX_L;
                fire    = 1'b1;
                tx_byte = rd_data[7:0];
                ph_n    = PH_SKIP;
              end else begin
                state_n = ST_IDLE;
                ph_n    = PH_SEND;
              end
            end
          end
        endcase
      end
      default: begin
        state_n = ST_IDLE;
        ph_n    = PH_SEND;
      end
    endcase

    if (to_expired) begin
      state_n = ST_IDLE;
      ph_n    = PH_SEND;
    end
  end

  // State, frame registers and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state          <= ST_IDLE;
      tx_ph          <= PH_SEND;
      is_wr          <= 1'b0;
      addr_hi        <= 8'h00;
      addr_lo        <= 8'h00;
      data_hi        <= 8'h00;
      rd_data        <= '0;
      o_tx_data      <= 8'h00;
      o_tx_start     <= 1'b0;
      o_addr_bus_per <= '0;
      o_cs_perif     <= 1'b0;
      o_w_r_per      <= 1'b0;
      o_data_per     <= '0;
      o_data_oe      <= 1'b0;
      o_cpu_hold     <= 1'b0;
    end else begin
      state      <= state_n;
      tx_ph      <= ph_n;
      o_tx_start <= fire;
      if (fire) o_tx_data <= tx_byte;

      o_cs_perif <= go_wr | go_rd;
      o_w_r_per  <= go_wr;
      o_data_oe  <= go_wr;
      if (go_wr || go_rd) o_addr_bus_per <= addr_next[ADDR_BUS_WIDTH-1:0];
      if (go_wr) o_data_per <= {data_hi, i_rx_data};

      // Falls on the cycle IDLE is entered and rises the cycle after the
      // first byte is taken.
      o_cpu_hold <= (state_n != ST_IDLE);

      if (state == ST_IDLE && i_rx_valid) is_wr   <= (i_rx_data == CMD_WR);
      if (state == ST_A_H  && i_rx_valid) addr_hi <= i_rx_data;
      if (state == ST_A_L  && i_rx_valid) addr_lo <= i_rx_data;
      if (state == ST_D_H  && i_rx_valid) data_hi <= i_rx_data;
      if (state == ST_RD_CAP)             rd_data <= i_data_per;
    end
  end

endmodule
